// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types and default sizes for the SRAM arbiter
// Contents: FSM state enum, requester id enum, default address/data widths.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        REQ_FILL  = 1'b0,
        REQ_ALPHA = 1'b1
    } req_id_t;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 1536;

endpackage

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin sequencer sharing one SRAM port between fill and alpha engines
// Ports:
//   clk, n_rst                         clock, asynchronous active-low reset
//   f_req/f_write/f_address/f_write_data -> f_ack   fill requester (req held until ack)
//   a_req/a_write/a_address/a_write_data -> a_ack   alpha requester (req held until ack)
//   rd_data                            captured read data, valid in the ack cycle of a read
//   busy                               high whenever the FSM is not idle
//   read_enable/write_enable/address/write_data -> SRAM, read_data <- SRAM
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              f_req,
    input  logic              f_write,
    input  logic [ADDR_W-1:0] f_address,
    input  logic [DATA_W-1:0] f_write_data,
    output logic              f_ack,
    input  logic              a_req,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [DATA_W-1:0] a_write_data,
    output logic              a_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              read_enable,
    output logic              write_enable,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_id_t     gnt_q, gnt_d;
    req_id_t     last_q, last_d;

    logic              re_d, we_d, fack_d, aack_d, busy_d, cap_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wd_d;

    // Round-robin pick: a lone request wins outright, a tie goes to whoever
    // was not served last.
    req_id_t           pick;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wd;

    always_comb begin
        if (f_req && a_req) begin
            pick = (last_q == REQ_FILL) ? REQ_ALPHA : REQ_FILL;
        end else if (f_req) begin
            pick = REQ_FILL;
        end else begin
            pick = REQ_ALPHA;
        end
    end

    assign sel_write = (pick == REQ_FILL) ? f_write      : a_write;
    assign sel_addr  = (pick == REQ_FILL) ? f_address    : a_address;
    assign sel_wd    = (pick == REQ_FILL) ? f_write_data : a_write_data;

    // The SRAM-facing output registers double as the latch for the granted
    // address/data: they are loaded at grant and simply held until DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wd_d    = '0;
        fack_d  = 1'b0;
        aack_d  = 1'b0;
        cap_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (f_req || a_req) begin
                    gnt_d  = pick;
                    addr_d = sel_addr;
                    if (sel_write) begin
                        state_d = WRITE;
                        cnt_d   = WR_CNT;
                        we_d    = 1'b1;
                        wd_d    = sel_wd;
                    end else begin
                        state_d = READ;
                        cnt_d   = RD_CNT;
                        re_d    = 1'b1;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    cap_d   = 1'b1;
                    fack_d  = (gnt_q == REQ_FILL);
                    aack_d  = (gnt_q == REQ_ALPHA);
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    re_d   = 1'b1;
                    addr_d = address;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    fack_d  = (gnt_q == REQ_FILL);
                    aack_d  = (gnt_q == REQ_ALPHA);
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    we_d   = 1'b1;
                    addr_d = address;
                    wd_d   = write_data;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = gnt_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            gnt_q        <= REQ_FILL;
            last_q       <= REQ_ALPHA;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            f_ack        <= 1'b0;
            a_ack        <= 1'b0;
            busy         <= 1'b0;
            rd_data      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            last_q       <= last_d;
            read_enable  <= re_d;
            write_enable <= we_d;
            address      <= addr_d;
            write_data   <= wd_d;
            f_ack        <= fack_d;
            a_ack        <= aack_d;
            busy         <= busy_d;
            if (cap_d) begin
                rd_data <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter
module tb_sram_arbiter;

    localparam int AW     = 19;
    localparam int DW     = 1536;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          f_req, f_write, a_req, a_write;
    logic [AW-1:0] f_address, a_address, address;
    logic [DW-1:0] f_write_data, a_write_data, write_data, read_data, rd_data;
    logic          f_ack, a_ack, busy, read_enable, write_enable;

    always #5 clk = ~clk;

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .f_req(f_req), .f_write(f_write), .f_address(f_address),
        .f_write_data(f_write_data), .f_ack(f_ack),
        .a_req(a_req), .a_write(a_write), .a_address(a_address),
        .a_write_data(a_write_data), .a_ack(a_ack),
        .rd_data(rd_data), .busy(busy),
        .read_enable(read_enable), .write_enable(write_enable),
        .address(address), .write_data(write_data), .read_data(read_data)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one access is described by its start (decision) cycle;
    // every output follows from its phase = cycle - start.
    int            cyc;
    int            m_start;
    bit            m_id;      // 0 = fill, 1 = alpha
    bit            m_w;
    bit            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;
    bit            exp_fack, exp_aack;
    bit            hold_f, hold_a;
    int            f_ack_cyc, a_ack_cyc, we_cnt;
    int            ack_ids[$];
    int            ack_cycs[$];

    function automatic logic [31:0] fold(input logic [DW-1:0] v);
        logic [31:0] r = '0;
        for (int i = 0; i < DW / 32; i++) r ^= v[i*32 +: 32];
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %h (fold %h) expected %h (fold %h)",
                   tag, cyc, obs[63:0], fold(obs), exp[63:0], fold(exp));
        end
    endtask

    function automatic int m_lat();
        return m_w ? WR_LAT : RD_LAT;
    endfunction

    function automatic bit m_active();
        int ph = cyc - m_start;
        return (ph >= 1) && (ph <= m_lat() + 1);
    endfunction

    task automatic model_reset();
        m_start = -1000;
        m_last  = 1'b1;
        m_rd    = '0;
        m_w     = 1'b0;
        cyc     = 0;
    endtask

    task automatic check_outputs();
        int            ph;
        bit            act, e_re, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        ph       = cyc - m_start;
        act      = m_active();
        e_re     = act && !m_w && (ph <= RD_LAT);
        e_we     = act &&  m_w && (ph <= WR_LAT);
        e_addr   = (e_re || e_we) ? m_addr : '0;
        e_wd     = e_we ? m_wd : '0;
        exp_fack = act && (ph == m_lat() + 1) && (m_id == 1'b0);
        exp_aack = act && (ph == m_lat() + 1) && (m_id == 1'b1);
        chk("busy",         DW'(busy),         DW'(act));
        chk("read_enable",  DW'(read_enable),  DW'(e_re));
        chk("write_enable", DW'(write_enable), DW'(e_we));
        chk("address",      DW'(address),      DW'(e_addr));
        chk("write_data",   write_data,        e_wd);
        chk("f_ack",        DW'(f_ack),        DW'(exp_fack));
        chk("a_ack",        DW'(a_ack),        DW'(exp_aack));
        chk("rd_data",      rd_data,           m_rd);
        chk("enable_excl",  DW'(read_enable & write_enable), '0);
        if (f_ack === 1'b1) begin f_ack_cyc = cyc; ack_ids.push_back(0); ack_cycs.push_back(cyc); end
        if (a_ack === 1'b1) begin a_ack_cyc = cyc; ack_ids.push_back(1); ack_cycs.push_back(cyc); end
        if (write_enable === 1'b1) we_cnt++;
    endtask

    // End-of-cycle model update using the inputs that were stable this cycle.
    task automatic model_eoc();
        int ph = cyc - m_start;
        if (m_active()) begin
            if (!m_w && ph == RD_LAT) m_rd = read_data;
            if (ph == m_lat() + 1) m_last = m_id;
        end else if (f_req || a_req) begin
            if (f_req && a_req) m_id = ~m_last;
            else                m_id = a_req;
            m_w     = m_id ? a_write : f_write;
            m_addr  = m_id ? a_address : f_address;
            m_wd    = m_id ? a_write_data : f_write_data;
            m_start = cyc;
        end
    endtask

    task automatic step();
        read_data = rand_data();
        @(negedge clk);
        check_outputs();
        model_eoc();
        @(posedge clk);
        #1;
        cyc++;
        if (exp_fack && !hold_f) f_req = 1'b0;
        if (exp_aack && !hold_a) a_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  DW'(busy),         '0);
        chk({tag, "_re"},    DW'(read_enable),  '0);
        chk({tag, "_we"},    DW'(write_enable), '0);
        chk({tag, "_addr"},  DW'(address),      '0);
        chk({tag, "_wd"},    write_data,        '0);
        chk({tag, "_fack"},  DW'(f_ack),        '0);
        chk({tag, "_aack"},  DW'(a_ack),        '0);
        chk({tag, "_rd"},    rd_data,           '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        n_rst = 1'b0;
        f_req = 1'b1; f_write = 1'b0; f_address = 19'h00040; f_write_data = '0;
        a_req = 1'b0; a_write = 1'b0; a_address = '0;        a_write_data = '0;
        read_data = '0; hold_f = 1'b0; hold_a = 1'b0;
        f_ack_cyc = -1; a_ack_cyc = -1; we_cnt = 0;
        model_reset();

        // Reset held with a pending fill request.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");

        // Release: fill read at 0x00040 starts immediately.
        @(posedge clk); #1;
        n_rst = 1'b1;
        model_reset();
        repeat (6) step();
        chk("fill_ack_cycle", DW'(f_ack_cyc), DW'(3));
        chk("fill_no_alpha_ack", DW'(a_ack_cyc), DW'(-1));

        // Alpha write.
        a_req = 1'b1; a_write = 1'b1; a_address = 19'h12C00;
        a_write_data = {512{3'b101}};
        t0 = cyc; we_cnt = 0;
        repeat (5) step();
        chk("alpha_ack_cycle", DW'(a_ack_cyc), DW'(t0 + 1 + WR_LAT));
        chk("alpha_we_cycles", DW'(we_cnt), DW'(WR_LAT));

        // Fill read whose request drops in cycle 1.
        f_req = 1'b1; f_write = 1'b0; f_address = 19'h7ABCD;
        t0 = cyc;
        step();
        f_req = 1'b0;
        repeat (5) step();
        chk("drop_ack_cycle", DW'(f_ack_cyc), DW'(t0 + RD_LAT + 1));

        // Asynchronous reset in the middle of an alpha write.
        a_req = 1'b1; a_write = 1'b1; a_address = 19'h00123; a_write_data = rand_data();
        a_ack_cyc = -1;
        step();
        #2;
        chk("we_before_async_rst", DW'(write_enable), DW'(1));
        n_rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (3) begin
            @(negedge clk);
            chk("rst_held_aack", DW'(a_ack), '0);
            chk("rst_held_busy", DW'(busy), '0);
        end

        // Tie after reset: both held continuously, reads, order F A F A.
        @(posedge clk); #1;
        model_reset();
        f_req = 1'b1; f_write = 1'b0; f_address = 19'h01111;
        a_req = 1'b1; a_write = 1'b0; a_address = 19'h02222;
        hold_f = 1'b1; hold_a = 1'b1;
        n_rst = 1'b1;
        ack_ids.delete(); ack_cycs.delete();
        repeat (17) step();
        chk("tie_ack_count", DW'(ack_ids.size()), DW'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < ack_ids.size()) begin
                chk($sformatf("tie_ack_id%0d", i),  DW'(ack_ids[i]),  DW'(i % 2));
                chk($sformatf("tie_ack_cyc%0d", i), DW'(ack_cycs[i]), DW'(3 + 4 * i));
            end
        end
        hold_f = 1'b0; hold_a = 1'b0;
        f_req = 1'b0; a_req = 1'b0;

        // Randomised traffic, including input changes while an access is in flight.
        for (int k = 0; k < 600; k++) begin
            if (!f_req && $urandom_range(0, 2) == 0) begin
                f_req = 1'b1; f_write = 1'($urandom_range(0, 1));
                f_address = AW'($urandom()); f_write_data = rand_data();
            end
            if (!a_req && $urandom_range(0, 2) == 0) begin
                a_req = 1'b1; a_write = 1'($urandom_range(0, 1));
                a_address = AW'($urandom()); a_write_data = rand_data();
            end
            if (m_active() && $urandom_range(0, 3) == 0) begin
                f_address = AW'($urandom()); a_write_data = rand_data();
                f_write = 1'($urandom_range(0, 1));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
